hdmi_frame_sequencer: RTL and testbench
=======================================

HDMI_FRAME_SEQUENCER -- requirements
Module: hdmi_frame_sequencer

Interface
REQ-001 Parameters SHALL be as follows; defaults are 640x480@60:
- H_ACTIVE = 640: active pixels per line.
- H_FP = 16: horizontal front porch, in pixels.
- H_SYNC = 96: hsync width, in pixels.
- H_BP = 48: horizontal back porch, in pixels.
- V_ACTIVE = 480: active lines per frame.
- V_FP = 10: vertical front porch, in lines.
- V_SYNC = 2: vsync width, in lines.
- V_BP = 33: vertical back porch, in lines.
- SYNC_POL = 0: sync polarity; 0 = active-low.
REQ-002 Ports SHALL be as follows:
- clk, input, 1: pixel clock.
- rstn, input, 1: asynchronous, active-low reset.
- run, input, 1: start/stop request.
- frameStart, output, 1: one-cycle pulse at the first active pixel of a frame.
- pixelReq, output, 1: high one cycle before each active pixel.
- pixelX, output, 12: column of the current pixel.
- pixelY, output, 12: line of the current pixel.
- encEnable, output, 1: drives enable of all three encoders.
- ch0Com, output, 2: {vsync,hsync} control code for channel 0.
- ch1Com, output, 2: {CTL1,CTL0} control code for channel 1.
- ch2Com, output, 2: {CTL3,CTL2} control code for channel 2.
- guardBand, output, 1: selects the package guard-band codes downstream.
- busy, output, 1: high while the sequencer is not idle.
REQ-003 One clock domain SHALL be used (clk); rstn SHALL be asynchronous and active-low.

Function
REQ-004 H_TOTAL SHALL equal H_ACTIVE+H_FP+H_SYNC+H_BP, and V_TOTAL SHALL equal V_ACTIVE+V_FP+V_SYNC+V_BP.
REQ-005 Internal counters SHALL be hcnt in 0..H_TOTAL-1 and vcnt in 0..V_TOTAL-1.
REQ-006 hcnt SHALL wrap to 0 at H_TOTAL-1 and increment vcnt; vcnt SHALL wrap to 0 at V_TOTAL-1.
REQ-007 Active video SHALL be hcnt<H_ACTIVE and vcnt<V_ACTIVE.
REQ-008 hsync SHALL be asserted for hcnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
REQ-009 vsync SHALL be asserted for vcnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC).
REQ-010 Asserted sync SHALL drive the pin level equal to SYNC_POL.
REQ-011 A line whose next line is active (vcnt+1<V_ACTIVE, or vcnt=V_TOTAL-1) SHALL have:
- a preamble at hcnt H_TOTAL-10..H_TOTAL-3;
- a guard band at hcnt H_TOTAL-2..H_TOTAL-1.
REQ-012 The horizontal FSM SHALL have states H_CTRL, H_PRE, H_GUARD and H_VIDEO.
REQ-013 FSM transitions SHALL be decoded from the counters per REQ-007 and REQ-011.
REQ-014 The top FSM SHALL have states IDLE and RUN.
REQ-015 In H_CTRL: encEnable=0, guardBand=0, ch0Com={vsync,hsync}, ch1Com=00, ch2Com=00.
REQ-016 In H_PRE: encEnable=0, ch1Com=01, ch2Com=00 (video preamble, CTL0=1).
REQ-017 In H_GUARD: encEnable=0 and guardBand=1.
REQ-018 In H_VIDEO: encEnable=1 and guardBand=0.
REQ-019 All outputs SHALL be registered.
REQ-020 pixelX/pixelY SHALL equal the hcnt/vcnt of the cycle whose encEnable they accompany.
REQ-021 pixelReq SHALL be high exactly one cycle before each encEnable=1 cycle (1-cycle RAM latency).
REQ-022 frameStart SHALL pulse together with the first encEnable of line 0.
REQ-023 In IDLE, rising run SHALL load hcnt=0, vcnt=V_TOTAL-1, enter RUN, and set busy=1.
REQ-024 run deasserted in RUN SHALL be honoured only at the wrap to vcnt=V_TOTAL-1, hcnt=0; the current frame always completes.
REQ-025 In IDLE: encEnable=0, guardBand=0, ch*Com=00 apart from inactive sync levels, and busy=0.
REQ-026 run toggling mid-frame SHALL have no effect other than REQ-024.

Reset
REQ-027 rstn low SHALL immediately force:
- IDLE state;
- counters to 0;
- encEnable=0, guardBand=0, pixelReq=0, frameStart=0, busy=0;
- pixelX=0, pixelY=0;
- ch0Com = inactive sync levels ({~SYNC_POL,~SYNC_POL}), ch1Com=00, ch2Com=00.
REQ-028 Reset mid-line SHALL abort without a completing pulse; restart SHALL follow REQ-023.

Structure
REQ-029 HDMIPackage SHALL hold:
- the VGB_CH0/VGB_CH2 code (1011001100) and the VGB_CH1 code (0100110011);
- the preamble CTL constants;
- the hstate_t enum.
REQ-030 One sub-module, hdmi_timing_counter, SHALL hold the hcnt/vcnt counters and wrap logic; the FSMs stay in the parent.

Verification
REQ-031 Default parameters, run=1 from reset: the first encEnable SHALL occur at pixelX=0, pixelY=0, with frameStart=1; there SHALL be 640 encEnable cycles per line and 480 active lines.
REQ-032 Cycles 790..797 of a line preceding an active line SHALL have ch1Com=01, and cycles 798..799 SHALL have guardBand=1; line 479 SHALL have neither.
REQ-033 With SYNC_POL=0, ch0Com[0] SHALL be low for hcnt 656..751, and ch0Com[1] SHALL be low for vcnt 490..491.
REQ-034 run dropped at line 100: the frame SHALL complete all 525 lines, then busy=0 and outputs SHALL be per REQ-025.
REQ-035 rstn pulsed low at pixel (320,200): outputs SHALL be at reset values in the same cycle, and run=1 afterward SHALL restart per REQ-023.
REQ-036 pixelReq SHALL lead encEnable by exactly 1 cycle on every active pixel; a scoreboard SHALL count 307200 matches per frame.

Source files
------------

// File: rtl/hdmi_frame_sequencer_pkg.sv
// Shared constants and types for the HDMI frame sequencer: TMDS guard-band
// codes, preamble control codes and the state enums.
package hdmi_frame_sequencer_pkg;

    localparam int CNT_W = 12;

    // Video guard-band TMDS characters selected downstream when guardBand=1
    localparam logic [9:0] VGB_CH0 = 10'b1011001100;
    localparam logic [9:0] VGB_CH1 = 10'b0100110011;
    localparam logic [9:0] VGB_CH2 = 10'b1011001100;

    // Video data period preamble: CTL0=1, CTL1=0, CTL2=0, CTL3=0
    localparam logic [1:0] PRE_CH1_CTL = 2'b01;
    localparam logic [1:0] PRE_CH2_CTL = 2'b00;

    // Preamble and guard band sit at the very end of the line before video
    localparam int PRE_LEN   = 8;
    localparam int GUARD_LEN = 2;

    typedef enum logic [1:0] {
        H_CTRL,
        H_PRE,
        H_GUARD,
        H_VIDEO
    } hstate_t;

    typedef enum logic {
        IDLE,
        RUN
    } seq_state_t;

endpackage

// File: rtl/hdmi_timing_counter.sv
// Horizontal/vertical raster counters. The next-cycle values are exported so
// the parent can look one pixel ahead (pixel request to the line buffer).
module hdmi_timing_counter
    import hdmi_frame_sequencer_pkg::*;
#(
    parameter int H_TOTAL = 800,
    parameter int V_TOTAL = 525
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             load,
    input  logic             advance,
    output logic [CNT_W-1:0] hcnt,
    output logic [CNT_W-1:0] vcnt,
    output logic [CNT_W-1:0] hcnt_next,
    output logic [CNT_W-1:0] vcnt_next
);

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

    // Next raster position: load parks on the last line so the first frame
    // gets its preamble/guard band before line 0.
    always_comb begin
        hcnt_next = hcnt;
        vcnt_next = vcnt;
        if (load) begin
            hcnt_next = '0;
            vcnt_next = V_LAST;
        end else if (advance) begin
            if (hcnt == H_LAST) begin
                hcnt_next = '0;
                vcnt_next = (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
            end else begin
                hcnt_next = hcnt + 1'b1;
            end
        end
    end

    // Counter registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            hcnt <= '0;
            vcnt <= '0;
        end else begin
            hcnt <= hcnt_next;
            vcnt <= vcnt_next;
        end
    end

endmodule

// File: rtl/hdmi_frame_sequencer.sv
// HDMI frame sequencer: walks the raster and produces registered control
// codes, encoder enable, guard-band select and pixel fetch requests. Every
// output reflects the raster position of the previous cycle; pixelReq looks
// one position further ahead to cover the one-cycle pixel RAM latency.
module hdmi_frame_sequencer
    import hdmi_frame_sequencer_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int SYNC_POL = 0
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        run,
    output logic        frameStart,
    output logic        pixelReq,
    output logic [11:0] pixelX,
    output logic [11:0] pixelY,
    output logic        encEnable,
    output logic [1:0]  ch0Com,
    output logic [1:0]  ch1Com,
    output logic [1:0]  ch2Com,
    output logic        guardBand,
    output logic        busy
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_ACT_C     = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT_C     = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT_M1    = CNT_W'(V_ACTIVE - 1);
    localparam logic [CNT_W-1:0] HS_START    = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END      = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_START    = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END      = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CNT_W-1:0] PRE_START   = CNT_W'(H_TOTAL - PRE_LEN - GUARD_LEN);
    localparam logic [CNT_W-1:0] GUARD_START = CNT_W'(H_TOTAL - GUARD_LEN);
    localparam logic [CNT_W-1:0] H_LAST      = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST      = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_END       = CNT_W'(V_TOTAL - 2);

    localparam logic SYNC_ON  = (SYNC_POL != 0);
    localparam logic SYNC_OFF = ~SYNC_ON;

    seq_state_t       state;
    hstate_t          hstate;
    logic [CNT_W-1:0] hcnt;
    logic [CNT_W-1:0] vcnt;
    logic [CNT_W-1:0] hcnt_next;
    logic [CNT_W-1:0] vcnt_next;
    logic             start;
    logic             frame_end;
    logic             run_next;
    logic             video_next;
    logic             pre_line;
    logic             hsync;
    logic             vsync;

    hdmi_timing_counter #(
        .H_TOTAL(H_TOTAL),
        .V_TOTAL(V_TOTAL)
    ) u_counter (
        .clk      (clk),
        .rstn     (rstn),
        .load     (start),
        .advance  (state == RUN),
        .hcnt     (hcnt),
        .vcnt     (vcnt),
        .hcnt_next(hcnt_next),
        .vcnt_next(vcnt_next)
    );

    // Start/stop decisions; a stop request is only looked at on the last
    // pixel of the frame so a frame in flight always completes.
    always_comb begin
        start     = (state == IDLE) && run;
        frame_end = (state == RUN) && (hcnt == H_LAST) && (vcnt == V_END);
        run_next  = (state == IDLE) ? run : !(frame_end && !run);
        video_next = (hcnt_next < H_ACT_C) && (vcnt_next < V_ACT_C);
    end

    // Horizontal state and sync decode of the current raster position
    always_comb begin
        hsync    = (hcnt >= HS_START) && (hcnt < HS_END);
        vsync    = (vcnt >= VS_START) && (vcnt < VS_END);
        pre_line = (vcnt < V_ACT_M1) || (vcnt == V_LAST);
        hstate   = H_CTRL;
        if ((hcnt < H_ACT_C) && (vcnt < V_ACT_C)) begin
            hstate = H_VIDEO;
        end else if (pre_line && (hcnt >= GUARD_START)) begin
            hstate = H_GUARD;
        end else if (pre_line && (hcnt >= PRE_START)) begin
            hstate = H_PRE;
        end
    end

    // Top FSM and registered outputs
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            busy       <= 1'b0;
            pixelReq   <= 1'b0;
            frameStart <= 1'b0;
            encEnable  <= 1'b0;
            guardBand  <= 1'b0;
            pixelX     <= '0;
            pixelY     <= '0;
            ch0Com     <= {SYNC_OFF, SYNC_OFF};
            ch1Com     <= 2'b00;
            ch2Com     <= 2'b00;
        end else begin
            state    <= run_next ? RUN : IDLE;
            busy     <= run_next;
            pixelReq <= run_next && video_next;
            if (state == RUN) begin
                frameStart <= (hcnt == '0) && (vcnt == '0);
                encEnable  <= (hstate == H_VIDEO);
                guardBand  <= (hstate == H_GUARD);
                pixelX     <= hcnt;
                pixelY     <= vcnt;
                ch0Com     <= {vsync ? SYNC_ON : SYNC_OFF, hsync ? SYNC_ON : SYNC_OFF};
                ch1Com     <= (hstate == H_PRE) ? PRE_CH1_CTL : 2'b00;
                ch2Com     <= (hstate == H_PRE) ? PRE_CH2_CTL : 2'b00;
            end else begin
                frameStart <= 1'b0;
                encEnable  <= 1'b0;
                guardBand  <= 1'b0;
                pixelX     <= '0;
                pixelY     <= '0;
                ch0Com     <= {SYNC_OFF, SYNC_OFF};
                ch1Com     <= 2'b00;
                ch2Com     <= 2'b00;
            end
        end
    end

endmodule

// File: tb/tb_hdmi_frame_sequencer.sv
// Scoreboard bench for hdmi_frame_sequencer on a reduced raster.
module tb_hdmi_frame_sequencer;

    localparam int HA = 16, HFP = 4, HSW = 6, HBP = 14;
    localparam int VA = 6, VFP = 2, VSW = 2, VBP = 3;
    localparam int HT = HA + HFP + HSW + HBP;
    localparam int VT = VA + VFP + VSW + VBP;
    localparam int FRAME = HT * VT;
    localparam bit POL = 1'b0;

    typedef struct packed {
        logic        fs;
        logic        req;
        logic [11:0] x;
        logic [11:0] y;
        logic        en;
        logic [1:0]  c0;
        logic [1:0]  c1;
        logic [1:0]  c2;
        logic        gb;
        logic        busy;
    } out_t;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        run = 1'b0;
    logic        frameStart, pixelReq, encEnable, guardBand, busy;
    logic [11:0] pixelX, pixelY;
    logic [1:0]  ch0Com, ch1Com, ch2Com;

    out_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    hdmi_frame_sequencer #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
        .SYNC_POL(0)
    ) dut (
        .clk(clk), .rstn(rstn), .run(run),
        .frameStart(frameStart), .pixelReq(pixelReq),
        .pixelX(pixelX), .pixelY(pixelY), .encEnable(encEnable),
        .ch0Com(ch0Com), .ch1Com(ch1Com), .ch2Com(ch2Com),
        .guardBand(guardBand), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic out_t idle_out(bit busy_v);
        out_t o;
        o = '0;
        o.c0 = {!POL, !POL};
        o.busy = busy_v;
        return o;
    endfunction

    // Frame position p counts from the first pixel of the pre-frame line (VT-1)
    function automatic bit pos_active(int p);
        int line, h, v;
        line = p / HT;
        h = p % HT;
        v = (line == 0) ? VT - 1 : line - 1;
        return (h < HA) && (v < VA);
    endfunction

    function automatic out_t pos_out(int p, bit busy_v, bit req);
        out_t o;
        int line, h, v;
        bit act, pl, hs, vs;
        line = p / HT;
        h = p % HT;
        v = (line == 0) ? VT - 1 : line - 1;
        act = (h < HA) && (v < VA);
        pl = (v + 1 < VA) || (v == VT - 1);
        hs = (h >= HA + HFP) && (h < HA + HFP + HSW);
        vs = (v >= VA + VFP) && (v < VA + VFP + VSW);
        o.fs = (h == 0) && (v == 0);
        o.req = req;
        o.x = 12'(h);
        o.y = 12'(v);
        o.en = act;
        o.c0 = {vs ? POL : !POL, hs ? POL : !POL};
        o.c1 = (!act && pl && h >= HT - 10 && h <= HT - 3) ? 2'b01 : 2'b00;
        o.c2 = 2'b00;
        o.gb = !act && pl && (h >= HT - 2);
        o.busy = busy_v;
        return o;
    endfunction

    // Reference model: predicts what the outputs show after each clock edge
    bit m_running = 1'b0;
    int m_pos = 0;
    always @(posedge clk) begin : model
        out_t o;
        bit nr;
        int np;
        if (!rstn) begin
            m_running = 1'b0;
            o = idle_out(1'b0);
        end else if (m_running) begin
            nr = !((m_pos == FRAME - 1) && !run);
            np = (m_pos + 1) % FRAME;
            o = pos_out(m_pos, nr, nr && pos_active(np));
            m_running = nr;
            if (nr) m_pos = np;
        end else begin
            nr = run;
            o = idle_out(nr);
            if (nr) begin
                m_running = 1'b1;
                m_pos = 0;
            end
        end
        exp_q.push_back(o);
    end

    // Monitor state for the pixelReq lead and per-frame pixel counts
    bit prev_req = 1'b0, prev_valid = 1'b0, prev_busy = 1'b0, in_frame = 1'b0;
    int enc_cnt = 0, lead_cnt = 0;

    task automatic frame_check();
        checks++;
        if (enc_cnt != HA * VA) begin
            errors++;
            $display("FAIL frame_enc_count got %0d want %0d", enc_cnt, HA * VA);
        end
        checks++;
        if (lead_cnt != HA * VA) begin
            errors++;
            $display("FAIL frame_req_matches got %0d want %0d", lead_cnt, HA * VA);
        end
    endtask

    // Monitor: pops a prediction every cycle and compares away from the edge
    always @(negedge clk) begin : monitor
        out_t a, e;
        a = {frameStart, pixelReq, pixelX, pixelY, encEnable,
             ch0Com, ch1Com, ch2Com, guardBand, busy};
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty at %0t act=%h", $time, a);
        end else begin
            e = exp_q.pop_front();
            if (!rstn) e = idle_out(1'b0);
            if (a !== e) begin
                errors++;
                $display("FAIL outputs at %0t act=%h exp=%h (act x=%0d y=%0d en=%b req=%b c0=%b c1=%b gb=%b busy=%b; exp x=%0d y=%0d en=%b req=%b c0=%b c1=%b gb=%b busy=%b)",
                         $time, a, e, a.x, a.y, a.en, a.req, a.c0, a.c1, a.gb, a.busy,
                         e.x, e.y, e.en, e.req, e.c0, e.c1, e.gb, e.busy);
            end
        end
        if (!rstn) begin
            prev_valid = 1'b0;
            prev_busy = 1'b0;
            in_frame = 1'b0;
            enc_cnt = 0;
            lead_cnt = 0;
        end else begin
            if (a.fs) begin
                if (in_frame) frame_check();
                in_frame = 1'b1;
                enc_cnt = 0;
                lead_cnt = 0;
            end
            if (prev_valid && (prev_req || a.en)) begin
                checks++;
                if (prev_req !== a.en) begin
                    errors++;
                    $display("FAIL req_lead at %0t prev_req=%b en=%b", $time, prev_req, a.en);
                end else begin
                    lead_cnt++;
                end
            end
            if (a.en) enc_cnt++;
            if (prev_busy && !a.busy && in_frame) begin
                frame_check();
                in_frame = 1'b0;
            end
            prev_req = a.req;
            prev_busy = a.busy;
            prev_valid = 1'b1;
        end
    end

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 2 * FRAME + 10) begin
            @(posedge clk);
            #2;
            n++;
        end
        checks++;
        if (busy) begin
            errors++;
            $display("FAIL %s busy=%b after %0d cycles, want 0", name, busy, n);
        end
    endtask

    task automatic reset_at(input int x, input int y, input string name);
        int n;
        n = 0;
        while (!(encEnable && pixelX == 12'(x) && pixelY == 12'(y)) && n < 2 * FRAME + 10) begin
            @(posedge clk);
            #2;
            n++;
        end
        checks++;
        if (!(encEnable && pixelX == 12'(x) && pixelY == 12'(y))) begin
            errors++;
            $display("FAIL %s pixel (%0d,%0d) not reached, at (%0d,%0d)", name, x, y, pixelX, pixelY);
        end
        rstn = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || encEnable !== 1'b0 || pixelX !== 12'd0 || pixelY !== 12'd0 ||
            ch0Com !== {!POL, !POL} || pixelReq !== 1'b0 || guardBand !== 1'b0) begin
            errors++;
            $display("FAIL %s_async busy=%b en=%b x=%0d y=%0d c0=%b req=%b gb=%b, want reset values",
                     name, busy, encEnable, pixelX, pixelY, ch0Com, pixelReq, guardBand);
        end
        repeat (3) @(posedge clk);
        #2 rstn = 1'b1;
    endtask

    initial begin
        rstn = 1'b0;
        run = 1'b1;
        repeat (4) @(posedge clk);
        #2 rstn = 1'b1;

        // Continuous run from reset
        repeat (FRAME + FRAME / 2) @(posedge clk);

        // Random run toggling: stops only land on frame boundaries
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #2;
            if ($urandom_range(0, 99) < 10) run = ~run;
        end

        // Orderly stop and idle period
        @(posedge clk);
        #2 run = 1'b0;
        wait_idle("stop_timeout");
        repeat (20) @(posedge clk);

        // Restart, then reset mid-line at the middle of a line
        #2 run = 1'b1;
        reset_at(HA / 2, VA / 2, "reset_mid");
        repeat (FRAME + 50) @(posedge clk);

        // Random-position reset, restart, then stop
        repeat ($urandom_range(50, 400)) @(posedge clk);
        #2 rstn = 1'b0;
        repeat (2) @(posedge clk);
        #2 rstn = 1'b1;
        repeat (FRAME + 30) @(posedge clk);
        #2 run = 1'b0;
        wait_idle("final_stop_timeout");
        repeat (10) @(posedge clk);
        @(negedge clk);
        #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
